// File: rtl/c64_bus_arbiter.sv
// rtl/c64_bus_arbiter.sv - C64-style phase-interleaved CPU/VIC bus arbiter with badline cycle stealing
module c64_bus_arbiter #(
    parameter int STEAL_DELAY = 3,
    parameter int AW          = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_ab,
    input  logic [7:0]    cpu_do,
    input  logic          cpu_we,
    output logic [7:0]    cpu_di,
    output logic          cpu_di_valid,
    output logic          cpu_rdy,
    output logic          cpu_slot,
    input  logic [AW-1:0] vic_ab,
    input  logic          vic_req,
    output logic [7:0]    vic_di,
    output logic          vic_di_valid,
    output logic          aec,
    output logic [AW-1:0] mem_ab,
    output logic [7:0]    mem_do,
    output logic          mem_we,
    input  logic [7:0]    mem_di
);

    typedef enum logic [1:0] {
        CPU_OWN    = 2'd0,
        STEAL_WAIT = 2'd1,
        VIC_OWN    = 2'd2
    } state_t;

    localparam logic [2:0] DELAY_INIT = 3'(STEAL_DELAY);

    state_t     state_q;
    logic       phase_q;
    logic [2:0] cnt_q;
    logic [7:0] cpu_di_q;
    logic [7:0] vic_di_q;
    logic       cpu_di_valid_q;
    logic       vic_di_valid_q;

    // The VIC owns even slots always, and every slot once the steal has completed.
    logic vic_slot;
    // CPU reads are only honoured while BA is high; reads during the steal window stall.
    logic cpu_cap;

    assign vic_slot = !phase_q || (state_q == VIC_OWN);
    assign cpu_cap  = phase_q && (state_q == CPU_OWN) && !cpu_we;

    assign cpu_slot     = phase_q;
    assign cpu_rdy      = (state_q == CPU_OWN);
    assign aec          = (state_q != VIC_OWN);
    assign cpu_di       = cpu_di_q;
    assign vic_di       = vic_di_q;
    assign cpu_di_valid = cpu_di_valid_q;
    assign vic_di_valid = vic_di_valid_q;

    // Bus mux: a CPU slot outside VIC_OWN passes writes straight through, so writes
    // keep working during the steal window; reset masks any write.
    always_comb begin
        mem_ab = cpu_ab;
        mem_do = cpu_do;
        mem_we = 1'b0;
        if (vic_slot) begin
            mem_ab = vic_ab;
            mem_do = 8'h00;
        end else begin
            mem_we = cpu_we;
        end
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    // Phase toggle, read-data capture and ownership state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q        <= 1'b0;
            state_q        <= CPU_OWN;
            cnt_q          <= DELAY_INIT;
            cpu_di_q       <= 8'h00;
            vic_di_q       <= 8'h00;
            cpu_di_valid_q <= 1'b0;
            vic_di_valid_q <= 1'b0;
        end else begin
            phase_q        <= ~phase_q;
            cpu_di_valid_q <= 1'b0;
            vic_di_valid_q <= 1'b0;
            if (vic_slot) begin
                vic_di_q       <= mem_di;
                vic_di_valid_q <= 1'b1;
            end
            if (cpu_cap) begin
                cpu_di_q       <= mem_di;
                cpu_di_valid_q <= 1'b1;
            end
            case (state_q)
                CPU_OWN: begin
                    if (vic_req) begin
                        state_q <= STEAL_WAIT;
                        cnt_q   <= DELAY_INIT;
                    end
                end
                STEAL_WAIT: begin
                    // A dropped request aborts the steal even on the slot the count expires.
                    if (!vic_req) begin
                        state_q <= CPU_OWN;
                    end else if (phase_q) begin
                        if (cnt_q == 3'd1) begin
                            state_q <= VIC_OWN;
                        end else begin
                            cnt_q <= cnt_q - 3'd1;
                        end
                    end
                end
                VIC_OWN: begin
                    // Release only at a VIC-slot edge so the CPU gets a whole CPU slot next.
                    if (!phase_q && !vic_req) begin
                        state_q <= CPU_OWN;
                    end
                end
                default: begin
                    state_q <= CPU_OWN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// tb/tb_c64_bus_arbiter.sv - self-checking bench for c64_bus_arbiter
module tb_c64_bus_arbiter;

    localparam int STEAL_DELAY = 3;
    localparam int AW          = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_ab;
    logic [7:0]    cpu_do;
    logic          cpu_we;
    logic [7:0]    cpu_di;
    logic          cpu_di_valid;
    logic          cpu_rdy;
    logic          cpu_slot;
    logic [AW-1:0] vic_ab;
    logic          vic_req;
    logic [7:0]    vic_di;
    logic          vic_di_valid;
    logic          aec;
    logic [AW-1:0] mem_ab;
    logic [7:0]    mem_do;
    logic          mem_we;
    logic [7:0]    mem_di;
    logic [7:0]    salt;

    c64_bus_arbiter #(.STEAL_DELAY(STEAL_DELAY), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
        .cpu_di(cpu_di), .cpu_di_valid(cpu_di_valid),
        .cpu_rdy(cpu_rdy), .cpu_slot(cpu_slot),
        .vic_ab(vic_ab), .vic_req(vic_req),
        .vic_di(vic_di), .vic_di_valid(vic_di_valid),
        .aec(aec),
        .mem_ab(mem_ab), .mem_do(mem_do), .mem_we(mem_we), .mem_di(mem_di)
    );

    always #5 clk = ~clk;

    // Memory model: read data is a function of the address so a wrong address shows up in captures.
    function automatic logic [7:0] hash(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ salt;
    endfunction
    assign mem_di = hash(mem_ab);

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a request episode is "active" from acceptance until release;
    // the VIC steals once the CPU has seen STEAL_DELAY CPU slots inside the episode.
    bit         m_phase;
    bit         m_active;
    int         m_waited;
    logic [7:0] m_cpu_di, m_vic_di;
    bit         m_cpu_v, m_vic_v;

    int obs_rdy_low, obs_aec_low, obs_sw, obs_vic_we;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_active = 0; m_waited = 0;
        m_cpu_di = 8'h00; m_vic_di = 8'h00; m_cpu_v = 0; m_vic_v = 0;
    endtask

    // Check one cycle against the model, then advance the model across the clock edge.
    task automatic cycle();
        bit             stolen, vslot, n_phase, n_active, n_cpu_v, n_vic_v;
        int             n_waited;
        logic [7:0]     n_cpu_di, n_vic_di;
        logic [AW-1:0]  e_ab;
        logic           e_we;
        #2;
        stolen = m_active && (m_waited >= STEAL_DELAY);
        vslot  = !m_phase || stolen;
        e_ab   = vslot ? vic_ab : cpu_ab;
        e_we   = (reset || vslot) ? 1'b0 : cpu_we;
        chk("cpu_slot", cpu_slot, m_phase);
        chk("cpu_rdy", cpu_rdy, !m_active);
        chk("aec", aec, !stolen);
        chk("mem_ab", mem_ab, e_ab);
        chk("mem_we", mem_we, e_we);
        if (vslot) chk("mem_do_vic", mem_do, 8'h00);
        if (e_we)  chk("mem_do_cpu", mem_do, cpu_do);
        chk("cpu_di", cpu_di, m_cpu_di);
        chk("cpu_di_valid", cpu_di_valid, m_cpu_v);
        chk("vic_di", vic_di, m_vic_di);
        chk("vic_di_valid", vic_di_valid, m_vic_v);
        if (cpu_rdy === 1'b0) obs_rdy_low++;
        if (aec === 1'b0) obs_aec_low++;
        if (cpu_rdy === 1'b0 && aec === 1'b1 && cpu_slot === 1'b1) obs_sw++;
        if (aec === 1'b0 && mem_we !== 1'b0) obs_vic_we++;

        n_phase = !m_phase; n_active = m_active; n_waited = m_waited;
        n_cpu_di = m_cpu_di; n_vic_di = m_vic_di; n_cpu_v = 0; n_vic_v = 0;
        if (vslot) begin n_vic_di = hash(e_ab); n_vic_v = 1; end
        if (m_phase && !m_active && !cpu_we) begin n_cpu_di = hash(e_ab); n_cpu_v = 1; end
        if (!m_active) begin
            if (vic_req) begin n_active = 1; n_waited = 0; end
        end else if (!stolen) begin
            if (!vic_req) n_active = 0;
            else if (m_phase) n_waited = m_waited + 1;
        end else begin
            if (!m_phase && !vic_req) n_active = 0;
        end
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            m_phase = n_phase; m_active = n_active; m_waited = n_waited;
            m_cpu_di = n_cpu_di; m_vic_di = n_vic_di; m_cpu_v = n_cpu_v; m_vic_v = n_vic_v;
        end
    endtask

    task automatic clear_obs();
        obs_rdy_low = 0; obs_aec_low = 0; obs_sw = 0; obs_vic_we = 0;
    endtask

    task automatic align_vic_slot();
        if (m_phase) cycle();
    endtask

    initial begin
        reset = 1; cpu_ab = 16'h1000; cpu_do = 8'h00; cpu_we = 1; vic_ab = 16'h0400;
        vic_req = 0; salt = 8'hB5;
        @(posedge clk);
        #1;
        model_reset();
        clear_obs();

        // Second reset cycle, with a CPU write pending that must be masked.
        cycle();
        reset = 0; cpu_we = 0;

        // Idle: CPU reads 0x1000 which returns 0xA5.
        for (int k = 0; k < 8; k++) begin
            vic_ab = 16'(16'h0400 + k);
            cycle();
        end
        chk("idle_read_data", cpu_di, 8'hA5);

        // Steal: request raised in a VIC slot and held 20 cycles.
        align_vic_slot();
        clear_obs();
        for (int k = 0; k < 21; k++) begin
            vic_req = (k < 20);
            vic_ab  = 16'(16'h0800 + k);
            cpu_we  = (k == 3) || (k >= 6 && k < 20);
            cpu_ab  = (k == 3) ? 16'hD020 : 16'h2000;
            cpu_do  = (k == 3) ? 8'h06 : 8'h5A;
            if (k == 3) begin
                #2;
                chk("sw_write_we", mem_we, 1'b1);
                chk("sw_write_do", mem_do, 8'h06);
            end
            cycle();
        end
        chk("steal_wait_cpu_slots", obs_sw, STEAL_DELAY);
        chk("vic_own_write_blocked", obs_vic_we, 0);
        chk("released_rdy", cpu_rdy, 1'b1);
        chk("released_aec", aec, 1'b1);
        cpu_we = 0;

        // One-cycle request glitch.
        clear_obs();
        vic_req = 1;
        cycle();
        vic_req = 0;
        repeat (4) cycle();
        chk("pulse_rdy_low_cycles", obs_rdy_low, 1);
        chk("pulse_aec_low_cycles", obs_aec_low, 0);

        // Request dropped on the very edge the count would expire.
        align_vic_slot();
        clear_obs();
        for (int k = 0; k < 9; k++) begin
            vic_req = (k < 5);
            cycle();
        end
        chk("abort_aec_low_cycles", obs_aec_low, 0);
        chk("abort_rdy_low_cycles", obs_rdy_low, 5);

        // Reset while the VIC owns the bus, with a CPU write pending.
        align_vic_slot();
        vic_req = 1; cpu_we = 1;
        repeat (10) cycle();
        chk("pre_reset_aec", aec, 1'b0);
        reset = 1;
        cycle();
        reset = 0; vic_req = 0; cpu_we = 0;
        #2;
        chk("post_reset_phase", cpu_slot, 1'b0);
        chk("post_reset_cpu_v", cpu_di_valid, 1'b0);
        chk("post_reset_vic_v", vic_di_valid, 1'b0);
        repeat (3) cycle();

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) vic_req = ~vic_req;
            reset  = ($urandom_range(0, 79) == 0);
            cpu_we = 1'($urandom_range(0, 1));
            cpu_ab = 16'($urandom);
            vic_ab = 16'($urandom);
            cpu_do = 8'($urandom);
            salt   = 8'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
